// File: rtl/p2ai_pkg.sv
// p2ai_pkg: action codes, FSM states and default Galois taps shared by the P2 AI.
package p2ai_pkg;

    localparam logic [2:0] ACT_IDLE    = 3'd0;
    localparam logic [2:0] ACT_FWD     = 3'd1;
    localparam logic [2:0] ACT_BACK    = 3'd2;
    localparam logic [2:0] ACT_ATK     = 3'd3;
    localparam logic [2:0] ACT_DIR_ATK = 3'd4;
    localparam logic [2:0] ACT_BLOCK   = 3'd5;

    typedef enum logic [1:0] {LOAD, WAIT, DRAW, HOLD} state_e;

    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_32 = 32'hA300_0000;

    function automatic logic [31:0] default_taps(input int w);
        return (w <= 8) ? TAPS_8 : (w <= 16) ? TAPS_16 : (w <= 24) ? TAPS_24 : TAPS_32;
    endfunction

endpackage

// File: rtl/galois_lfsr.sv
// galois_lfsr: free-running right-shift Galois LFSR with seed load; a zero seed or zero state becomes 1.
module galois_lfsr import p2ai_pkg::*; #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(default_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'hACE1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    output logic [LFSR_W-1:0] out
);

    localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Seed load has priority; an all-zero state recovers to 1 instead of locking up
    always_comb begin
        lfsr_d = load ? SEED_NZ : (lfsr_q == '0) ? LFSR_W'(1) : ((lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0));
    end

    // LFSR register, cleared to zero by reset and reloaded from the seed afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= '0;
        else lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;

endmodule

// File: rtl/p2ai_fsm.sv
// p2ai_fsm: player-2 AI that draws a random action and holds it for a random number of frames.
// Define REACTIVE_EN to let P1 distance/attack override the random draw.
module p2ai_fsm import p2ai_pkg::*; #(
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAPS        = LFSR_W'(default_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(32'hACE1),
    parameter int                ACT_W       = 3,
    parameter int                NUM_ACTIONS = 6,
    parameter int                ACT_LSB     = 8,
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_MIN    = 2,
    parameter logic [7:0]        NEAR_DIST   = 8'd24,
    parameter logic [7:0]        FAR_DIST    = 8'd96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              enable,
    input  logic [7:0]        p1_dist,
    input  logic              p1_attacking,
    output logic [ACT_W-1:0]  action,
    output logic              action_new,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int CNT_W = $clog2(HOLD_MIN + 2**HOLD_W);

    if (ACT_LSB + ACT_W > LFSR_W || HOLD_W >= LFSR_W) begin : g_bad_slice
        $error("p2ai_fsm: action or hold field does not fit in LFSR_W");
    end
    if (LFSR_W < 8 || LFSR_W > 32 || HOLD_MIN < 1) begin : g_bad_size
        $error("p2ai_fsm: LFSR_W must be 8..32 and HOLD_MIN at least 1");
    end
    if (NUM_ACTIONS <= 2**(ACT_W-1) || NUM_ACTIONS > 2**ACT_W) begin : g_bad_actions
        $error("p2ai_fsm: NUM_ACTIONS must lie in (2^(ACT_W-1), 2^ACT_W]");
    end

    state_e            state_q, state_d;
    logic [ACT_W-1:0]  action_q, action_d, raw, pick, draw_act;
    logic              action_new_q, action_new_d;
    logic [CNT_W-1:0]  hold_q, hold_d, hold_rand, draw_hold;
    logic [LFSR_W-1:0] lfsr;

    galois_lfsr #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == LOAD),
        .out   (lfsr)
    );

    // Random pick: one conditional subtraction folds the slice into 0..NUM_ACTIONS-1
    always_comb begin
        raw       = lfsr[ACT_LSB +: ACT_W];
        pick      = ({1'b0, raw} >= (ACT_W+1)'(NUM_ACTIONS)) ? raw - ACT_W'(NUM_ACTIONS) : raw;
        hold_rand = CNT_W'(HOLD_MIN) + CNT_W'(lfsr[HOLD_W-1:0]);
    end

`ifdef REACTIVE_EN
    logic near_attack, far_away;

    // Block a close attack first, then close in on a distant P1, else fall back to random
    always_comb begin
        near_attack = p1_attacking && (p1_dist < NEAR_DIST);
        far_away    = p1_dist > FAR_DIST;
        draw_act    = near_attack ? ACT_W'(ACT_BLOCK) : far_away ? ACT_W'(ACT_FWD) : pick;
        draw_hold   = (near_attack || far_away) ? CNT_W'(HOLD_MIN) : hold_rand;
    end
`else
    logic unused_p1;

    assign draw_act  = pick;
    assign draw_hold = hold_rand;
    assign unused_p1 = ^{p1_dist, p1_attacking};
`endif

    // Next state: LOAD runs once, WAIT arms on a tick, DRAW latches, HOLD counts frames
    always_comb begin
        state_d      = state_q;
        action_d     = action_q;
        hold_d       = hold_q;
        action_new_d = 1'b0;
        case (state_q)
            LOAD: state_d = WAIT;
            WAIT: state_d = frame_tick ? DRAW : WAIT;
            DRAW: begin
                action_d     = draw_act;
                hold_d       = draw_hold;
                action_new_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: if (frame_tick) begin
                hold_d  = hold_q - CNT_W'(1);
                state_d = (hold_q == CNT_W'(1)) ? DRAW : HOLD;
            end
        endcase
        if (state_q != LOAD && !enable) begin
            state_d      = WAIT;
            action_d     = '0;
            hold_d       = '0;
            action_new_d = 1'b0;
        end
    end

    // FSM and output registers, asynchronously returned to LOAD with an idle action
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            action_q     <= '0;
            action_new_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            action_q     <= action_d;
            action_new_q <= action_new_d;
            hold_q       <= hold_d;
        end
    end

    assign action     = action_q;
    assign action_new = action_new_q;
    assign lfsr_state = lfsr;

endmodule

// File: tb/tb_p2ai_fsm.sv
// tb_p2ai_fsm: randomized bench for p2ai_fsm across four seeds against a frame-level behavioural model.
module tb_p2ai_fsm;

    logic clk;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic enable = 1'b1;
    logic [7:0] p1_dist = 8'd50;
    logic p1_attacking = 1'b0;
    logic chk_en = 1'b0;

    logic [2:0]  act  [4];
    logic        anew [4];
    logic [15:0] lst  [4];

    int vectors = 0;
    int fails = 0;
    logic [2:0] run0[$], run1[$];

    function automatic logic [15:0] seed_of(input int g);
        return (g == 0) ? 16'hACE1 : (g == 1) ? 16'h0000 : (g == 2) ? 16'h0C00 : 16'h0E00;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        p2ai_fsm #(.SEED(seed_of(g))) u_dut (
            .clk          (clk),
            .reset        (reset),
            .frame_tick   (frame_tick),
            .enable       (enable),
            .p1_dist      (p1_dist),
            .p1_attacking (p1_attacking),
            .action       (act[g]),
            .action_new   (anew[g]),
            .lfsr_state   (lst[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference: integer frame countdown plus a "draw pending" flag
    function automatic logic [15:0] mstep(input logic [15:0] x);
        return (x == 16'h0) ? 16'h0001 : ((x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000));
    endfunction

    function automatic logic [2:0] mpick(input logic [15:0] l);
        int raw;
        raw = (int'(l) >> 8) % 8;
        return 3'((raw >= 6) ? raw - 6 : raw);
    endfunction

    logic [15:0] m_lfsr [4];
    logic [2:0]  m_act  [4];
    logic        m_new  [4];
    int          m_left [4];
    logic        m_draw [4];
    logic        m_load [4];

    always @(posedge clk or posedge reset) begin
        for (int g = 0; g < 4; g++) begin
            logic [15:0] l;
            logic [2:0] a;
            int left;
            logic dr;
            logic nw;
            l = m_lfsr[g];
            a = m_act[g];
            left = m_left[g];
            dr = m_draw[g];
            nw = 1'b0;
            if (reset) begin
                m_lfsr[g] <= 16'h0;
                m_act[g]  <= 3'd0;
                m_new[g]  <= 1'b0;
                m_left[g] <= 0;
                m_draw[g] <= 1'b0;
                m_load[g] <= 1'b1;
            end else begin
                m_lfsr[g] <= m_load[g] ? ((seed_of(g) == 16'h0) ? 16'h0001 : seed_of(g)) : mstep(l);
                if (!m_load[g]) begin
                    if (!enable) begin
                        a = 3'd0;
                        left = 0;
                        dr = 1'b0;
                    end else if (dr) begin
                        a = mpick(l);
                        left = 2 + int'(l[2:0]);
`ifdef REACTIVE_EN
                        if (p1_attacking && p1_dist < 8'd24) begin a = 3'd5; left = 2; end
                        else if (p1_dist > 8'd96) begin a = 3'd1; left = 2; end
`endif
                        nw = 1'b1;
                        dr = 1'b0;
                    end else if (frame_tick) begin
                        dr = (left <= 1);
                        left = (left > 0) ? left - 1 : 0;
                    end
                end
                m_load[g] <= 1'b0;
                m_act[g]  <= a;
                m_left[g] <= left;
                m_draw[g] <= dr;
                m_new[g]  <= nw;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 4; g++) begin
                vectors++;
                if (act[g] !== m_act[g] || anew[g] !== m_new[g] || lst[g] !== m_lfsr[g]) begin
                    fails++;
                    $display("FAIL model[%0d] t=%0t: action=%0d new=%0d lfsr=%h, expected action=%0d new=%0d lfsr=%h",
                             g, $time, act[g], anew[g], lst[g], m_act[g], m_new[g], m_lfsr[g]);
                end
                vectors++;
                if (act[g] >= 3'd6) begin
                    fails++;
                    $display("FAIL range[%0d] t=%0t: action=%0d, expected below 6", g, $time, act[g]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_new();
        int n;
        n = 0;
        do begin
            frame_tick = (n % 4 == 0);
            @(negedge clk);
            n++;
        end while (!anew[0] && n < 200);
        frame_tick = 1'b0;
        if (!anew[0]) begin
            vectors++;
            fails++;
            $display("FAIL wait_new: no action_new within 200 clks, expected a draw");
        end
    endtask

    task automatic det_phase(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            frame_tick = (i % 4 == 1);
            p1_dist = 8'd50;
            p1_attacking = 1'b0;
            @(negedge clk);
            if (anew[0]) begin
                if (sel == 0) run0.push_back(act[0]);
                else run1.push_back(act[0]);
            end
            if (sel == 0 && i == 0) begin
                check("seed0_loads_1", int'(lst[1]), 'h0001);
                check("seed_loads_ace1", int'(lst[0]), 'hACE1);
            end
            if (sel == 0 && i == 1) begin
                check("seed0_step1", int'(lst[1]), 'hB400);
                check("seed_step1", int'(lst[0]), 'hE270);
            end
            if (sel == 0 && i == 2) begin
                check("seed0_step2", int'(lst[1]), 'h5A00);
                check("seed0_first_act", int'(act[1]), 4);
                check("seed0_first_new", int'(anew[1]), 1);
                check("fold6_act", int'(act[2]), 0);
                check("fold6_new", int'(anew[2]), 1);
                check("fold7_act", int'(act[3]), 1);
                check("seed_first_act", int'(act[0]), 2);
            end
            if (sel == 0 && i == 10) check("seed0_hold2_redraw", int'(anew[1]), 1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_action", int'(act[0]), 0);
        check("reset_new", int'(anew[0]), 0);
        check("reset_lfsr", int'(lst[0]), 0);
        reset = 1'b0;
        det_phase(0, 400);

        wait_new();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("en_drop_action", int'(act[0]), 0);
        check("en_drop_new", int'(anew[0]), 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("reen_draw_cycle_new", int'(anew[0]), 0);
        @(negedge clk);
        check("reen_first_new", int'(anew[0]), 1);

`ifdef REACTIVE_EN
        p1_attacking = 1'b1;
        p1_dist = 8'd10;
        wait_new();
        check("react_block", int'(act[0]), 5);
        p1_attacking = 1'b0;
        p1_dist = 8'd120;
        wait_new();
        check("react_fwd", int'(act[0]), 1);
        p1_dist = 8'd50;
`endif

        for (int i = 0; i < 4000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            p1_dist = 8'($urandom_range(0, 255));
            p1_attacking = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        enable = 1'b1;
        p1_dist = 8'd50;
        p1_attacking = 1'b0;
        wait_new();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_action", int'(act[0]), 0);
        check("async_reset_new", int'(anew[0]), 0);
        check("async_reset_lfsr", int'(lst[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        det_phase(1, 400);
        check("rerun_len", run1.size(), run0.size());
        for (int i = 0; i < run0.size() && i < run1.size(); i++)
            check($sformatf("rerun_act%0d", i), int'(run1[i]), int'(run0[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
